// File: rtl/hd_rx_fifo_pkg.sv
// hd_rx_fifo_pkg: shared constants and width helper for the rx FIFO slice
package hd_rx_fifo_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/hd_rx_fifo_mem.sv
// hd_rx_fifo_mem: DEPTH x DATA_WIDTH storage, sync write, async read, no reset
module hd_rx_fifo_mem
  import hd_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]     rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/hd_rx_fifo.sv
// hd_rx_fifo: first-word fall-through FIFO with valid/ready on both sides
module hd_rx_fifo
  import hd_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        data_src,
  input  logic                         valid,
  output logic                         ready_output,
  output logic                         valid_output,
  output logic [DATA_WIDTH-1:0]        data_dest,
  input  logic                         ready,
  output logic [clog2(DEPTH+1)-1:0]    count
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH+1);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic push, pop;
  // flags come from count alone so ready never combinationally reaches ready_output
  assign ready_output = count != CW'(DEPTH);
  assign valid_output = count != '0;
  assign push = valid & ready_output;
  assign pop = valid_output & ready;
  assign data_dest = valid_output ? rd_data : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  hd_rx_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(push),
    .waddr(wr_ptr),
    .wdata(data_src),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_hd_rx_fifo.sv
// tb_hd_rx_fifo: directed self-checking bench for hd_rx_fifo (DEPTH=4, 32-bit)
module tb_hd_rx_fifo;
  logic clk, rst, valid, ready, ready_output, valid_output;
  logic [31:0] data_src, data_dest;
  logic [2:0] count;
  int checks = 0;
  int errors = 0;

  hd_rx_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .data_src(data_src), .valid(valid),
    .ready_output(ready_output), .valid_output(valid_output),
    .data_dest(data_dest), .ready(ready), .count(count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task test_reset;
    rst = 1; valid = 0; ready = 0; data_src = 0;
    @(negedge clk); rst = 0; valid = 1; data_src = 32'h5A;
    @(negedge clk); valid = 0;
    checks++; if (valid_output !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b want 1", valid_output); end
    #2 rst = 1;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (valid_output !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_output); end
    checks++; if (ready_output !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_output); end
    checks++; if (data_dest !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data_dest); end
    @(negedge clk); rst = 0;
  endtask

  task test_fill;
    logic [31:0] words [4];
    words = '{32'h11, 32'h22, 32'h33, 32'h44};
    ready = 0; valid = 1;
    for (int i = 0; i < 4; i++) begin
      data_src = words[i];
      @(negedge clk);
    end
    data_src = 32'h55;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", count); end
    checks++; if (ready_output !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b want 0", ready_output); end
    checks++; if (data_dest !== 32'h11) begin errors++; $display("FAIL fill_head: got %h want 11", data_dest); end
    @(negedge clk);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_fifth_rejected: got %0d want 4", count); end
  endtask

  task test_full_pop;
    logic [31:0] rest [3];
    rest = '{32'h22, 32'h33, 32'h44};
    ready = 1;
    checks++; if (data_dest !== 32'h11) begin errors++; $display("FAIL fullpop_head: got %h want 11", data_dest); end
    @(negedge clk);
    ready = 0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fullpop_count: got %0d want 3", count); end
    checks++; if (ready_output !== 1'b1) begin errors++; $display("FAIL fullpop_ready: got %b want 1", ready_output); end
    valid = 0;
    ready = 1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (data_dest !== rest[i]) begin errors++; $display("FAIL drain_%0d: got %h want %h", i, data_dest, rest[i]); end
      @(negedge clk);
    end
    ready = 0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count: got %0d want 0", count); end
    checks++; if (valid_output !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", valid_output); end
    checks++; if (data_dest !== 32'h0) begin errors++; $display("FAIL drain_data_zero: got %h want 0", data_dest); end
  endtask

  task test_streaming;
    valid = 1; ready = 1;
    for (int k = 0; k < 20; k++) begin
      data_src = k;
      if (k > 0) begin
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count_%0d: got %0d want 1", k, count); end
        checks++; if (data_dest !== 32'(k - 1)) begin errors++; $display("FAIL stream_data_%0d: got %0d want %0d", k, data_dest, k - 1); end
      end
      @(negedge clk);
    end
    valid = 0;
    checks++; if (data_dest !== 32'd19) begin errors++; $display("FAIL stream_last: got %0d want 19", data_dest); end
    @(negedge clk);
    ready = 0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_empty: got %0d want 0", count); end
  endtask

  task test_wrap;
    logic [31:0] q [$];
    int pushed, popped, cyc;
    bit do_push, do_pop;
    pushed = 0; popped = 0; cyc = 0;
    while ((pushed < 10 || popped < 10) && cyc < 300) begin
      valid = (pushed < 10) && ($urandom_range(0, 2) != 0);
      ready = $urandom_range(0, 2) != 0;
      data_src = 32'hC000 + pushed;
      do_push = valid && q.size() != 4;
      do_pop = ready && q.size() != 0;
      checks++; if (valid_output !== (q.size() != 0)) begin errors++; $display("FAIL wrap_valid_c%0d: got %b want %b", cyc, valid_output, q.size() != 0); end
      checks++; if (ready_output !== (q.size() != 4)) begin errors++; $display("FAIL wrap_ready_c%0d: got %b want %b", cyc, ready_output, q.size() != 4); end
      if (q.size() != 0) begin
        checks++; if (data_dest !== q[0]) begin errors++; $display("FAIL wrap_data_c%0d: got %h want %h", cyc, data_dest, q[0]); end
      end
      @(negedge clk);
      if (do_pop) begin void'(q.pop_front()); popped++; end
      if (do_push) begin q.push_back(32'hC000 + pushed); pushed++; end
      cyc++;
    end
    valid = 0; ready = 0;
    checks++; if (popped != 10) begin errors++; $display("FAIL wrap_budget: got %0d pops want 10", popped); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_end_count: got %0d want 0", count); end
  endtask

  task test_reset_traffic;
    valid = 1; ready = 0;
    for (int i = 0; i < 3; i++) begin
      data_src = 32'hD0 + i;
      @(negedge clk);
    end
    valid = 0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL rt_count3: got %0d want 3", count); end
    #2 rst = 1; valid = 1; data_src = 32'hEE;
    @(negedge clk);
    rst = 0; valid = 0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rt_no_push_in_reset: got %0d want 0", count); end
    checks++; if (valid_output !== 1'b0) begin errors++; $display("FAIL rt_valid_low: got %b want 0", valid_output); end
    valid = 1; data_src = 32'hAB;
    @(negedge clk);
    valid = 0;
    checks++; if (valid_output !== 1'b1) begin errors++; $display("FAIL rt_valid_rise: got %b want 1", valid_output); end
    checks++; if (data_dest !== 32'hAB) begin errors++; $display("FAIL rt_head: got %h want ab", data_dest); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL rt_count1: got %0d want 1", count); end
    ready = 1;
    @(negedge clk);
    ready = 0;
    checks++; if (valid_output !== 1'b0) begin errors++; $display("FAIL rt_no_old_data: got %b want 0", valid_output); end
    checks++; if (data_dest !== 32'h0) begin errors++; $display("FAIL rt_data_zero: got %h want 0", data_dest); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_full_pop;
    test_streaming;
    test_wrap;
    test_reset_traffic;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
